// File: rtl/miter_lockstep_monitor.sv
// Lockstep divergence monitor for a two-copy miter.
// It latches the first cycle in which the unmasked observation channels of copies A and B disagree.
module miter_lockstep_monitor #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 64,
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     mode_i,
  input  logic [NUM_CH-1:0]        mask_i,
  input  logic [NUM_CH-1:0]        valid_a_i,
  input  logic [NUM_CH-1:0]        valid_b_i,
  input  logic [NUM_CH*CH_W-1:0]   data_a_i,
  input  logic [NUM_CH*CH_W-1:0]   data_b_i,
  output logic                     active_o,
  output logic                     diverged_o,
  output logic [NUM_CH-1:0]        div_ch_o,
  output logic [CNT_W-1:0]         div_cycle_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_MONITOR  = 2'd2,
    S_DIVERGED = 2'd3
  } state_e;

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e              state_q, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    div_cycle_q, div_cycle_d;
  logic [NUM_CH-1:0]   div_ch_q, div_ch_d;
  logic                diverged_q, diverged_d;
  logic                mode_q, mode_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   mism;

  // Data only counts when both copies claim a valid event on that channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign mism[gi] = !mask_q[gi] &&
                      ((valid_a_i[gi] != valid_b_i[gi]) ||
                       (mode_q && valid_a_i[gi] && valid_b_i[gi] &&
                        (data_a_i[gi*CH_W +: CH_W] != data_b_i[gi*CH_W +: CH_W])));
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    div_cycle_d = div_cycle_q;
    div_ch_d    = div_ch_q;
    diverged_d  = diverged_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    if (clr_i) begin
      state_d     = S_IDLE;
      settle_d    = '0;
      cnt_d       = '0;
      div_cycle_d = '0;
      div_ch_d    = '0;
      diverged_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en_i) begin
            mode_d   = mode_i;
            mask_d   = mask_i;
            cnt_d    = '0;
            settle_d = SETTLE_LOAD;
            state_d  = (SETTLE_CYCLES == 0) ? S_MONITOR : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!en_i) begin
            state_d = S_IDLE;
          end else begin
            settle_d = settle_q - SW'(1);
            if (settle_q == SW'(1)) state_d = S_MONITOR;
          end
        end
        S_MONITOR: begin
          // A mismatch outranks disarming in the same cycle.
          if (|mism) begin
            state_d     = S_DIVERGED;
            div_ch_d    = mism;
            div_cycle_d = cnt_q;
            diverged_d  = 1'b1;
          end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (!en_i) state_d = S_IDLE;
          end
        end
        S_DIVERGED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      cnt_q       <= '0;
      div_cycle_q <= '0;
      div_ch_q    <= '0;
      diverged_q  <= 1'b0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      div_cycle_q <= div_cycle_d;
      div_ch_q    <= div_ch_d;
      diverged_q  <= diverged_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
    end
  end

  assign active_o    = (state_q == S_MONITOR);
  assign diverged_o  = diverged_q;
  assign div_ch_o    = div_ch_q;
  assign div_cycle_o = div_cycle_q;
  assign cycle_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_miter_lockstep_monitor.sv
// Bench for miter_lockstep_monitor: two instances (8-cycle settle / 32-bit counter, no settle / 4-bit counter)
// share stimulus and are checked each cycle against a behavioural model plus directed literal expectations.
module tb_miter_lockstep_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, mode = 1'b0;
  logic [3:0]  mask = '0, va = '0, vb = '0;
  logic [63:0] da = '0, db = '0;

  logic        act0, dv0, act1, dv1;
  logic [3:0]  dch0, dch1;
  logic [31:0] dcyc0, cnt0;
  logic [3:0]  dcyc1, cnt1;
  logic [1:0]  st0, st1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  miter_lockstep_monitor #(.NUM_CH(4), .CH_W(16), .CNT_W(32), .SETTLE_CYCLES(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode), .mask_i(mask),
    .valid_a_i(va), .valid_b_i(vb), .data_a_i(da), .data_b_i(db),
    .active_o(act0), .diverged_o(dv0), .div_ch_o(dch0), .div_cycle_o(dcyc0),
    .cycle_cnt_o(cnt0), .state_o(st0));

  miter_lockstep_monitor #(.NUM_CH(4), .CH_W(16), .CNT_W(4), .SETTLE_CYCLES(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode), .mask_i(mask),
    .valid_a_i(va), .valid_b_i(vb), .data_a_i(da), .data_b_i(db),
    .active_o(act1), .diverged_o(dv1), .div_ch_o(dch1), .div_cycle_o(dcyc1),
    .cycle_cnt_o(cnt1), .state_o(st1));

  // Behavioural model: phase 0..3 follows the published state numbering.
  int          m_phase [2];
  int          m_spent [2];
  longint      m_cnt   [2];
  bit          m_div   [2];
  logic [3:0]  m_dch   [2];
  longint      m_dcyc  [2];
  bit          m_mode  [2];
  logic [3:0]  m_mask  [2];

  function automatic int settle_of(int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic longint max_of(int i);
    return (i == 0) ? 64'd4294967295 : 64'd15;
  endfunction

  function automatic logic [3:0] mism(bit md, logic [3:0] mk);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      logic [15:0] x, y;
      x = da[c*16 +: 16];
      y = db[c*16 +: 16];
      r[c] = !mk[c] && ((va[c] != vb[c]) || (md && va[c] && vb[c] && (x != y)));
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0; m_spent[i] <= 0; m_cnt[i] <= 0; m_div[i] <= 1'b0;
        m_dch[i] <= '0; m_dcyc[i] <= 0; m_mode[i] <= 1'b0; m_mask[i] <= '0;
      end else if (clr) begin
        m_phase[i] <= 0; m_spent[i] <= 0; m_cnt[i] <= 0; m_div[i] <= 1'b0;
        m_dch[i] <= '0; m_dcyc[i] <= 0;
      end else begin
        case (m_phase[i])
          0: if (en) begin
               m_mode[i]  <= mode;
               m_mask[i]  <= mask;
               m_cnt[i]   <= 0;
               m_spent[i] <= 0;
               m_phase[i] <= (settle_of(i) == 0) ? 2 : 1;
             end
          1: if (!en) m_phase[i] <= 0;
             else begin
               m_spent[i] <= m_spent[i] + 1;
               if (m_spent[i] + 1 == settle_of(i)) m_phase[i] <= 2;
             end
          2: if (mism(m_mode[i], m_mask[i]) != 4'd0) begin
               m_phase[i] <= 3;
               m_div[i]   <= 1'b1;
               m_dch[i]   <= mism(m_mode[i], m_mask[i]);
               m_dcyc[i]  <= m_cnt[i];
             end else begin
               if (m_cnt[i] < max_of(i)) m_cnt[i] <= m_cnt[i] + 1;
               if (!en) m_phase[i] <= 0;
             end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("state0",  {62'd0, st0},  64'(m_phase[0]));
    chk("active0", {63'd0, act0}, {63'd0, m_phase[0] == 2});
    chk("div0",    {63'd0, dv0},  {63'd0, m_div[0]});
    chk("dch0",    {60'd0, dch0}, {60'd0, m_dch[0]});
    chk("dcyc0",   {32'd0, dcyc0}, m_dcyc[0]);
    chk("cnt0",    {32'd0, cnt0},  m_cnt[0]);
    chk("state1",  {62'd0, st1},  64'(m_phase[1]));
    chk("active1", {63'd0, act1}, {63'd0, m_phase[1] == 2});
    chk("div1",    {63'd0, dv1},  {63'd0, m_div[1]});
    chk("dch1",    {60'd0, dch1}, {60'd0, m_dch[1]});
    chk("dcyc1",   {60'd0, dcyc1}, m_dcyc[1]);
    chk("cnt1",    {60'd0, cnt1},  m_cnt[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clean();
    va = 4'($urandom);
    vb = va;
    da = {$urandom, $urandom};
    db = da;
  endtask

  initial begin
    // Reset with random inputs, then idle.
    en = 1'b1;
    repeat (3) begin
      clean(); vb = ~va; cycle();
    end
    rst_n = 1'b1; en = 1'b0;
    repeat (10) begin clean(); cycle(); end
    chk("idle_state", {62'd0, st0}, 64'd0);
    chk("idle_cnt", {32'd0, cnt0}, 64'd0);
    chk("idle_div", {62'd0, dv0, act0}, 64'd0);

    // Settle masking.
    mode = 1'b0; mask = '0; clean(); en = 1'b1;
    cycle();
    repeat (8) begin clean(); va = 4'b0001; vb = 4'b0000; cycle(); end
    chk("settle_active", {63'd0, act0}, 64'd1);
    chk("settle_nodiv", {63'd0, dv0}, 64'd0);
    repeat (20) begin clean(); cycle(); end
    chk("settle_cnt20", {32'd0, cnt0}, 64'd20);

    // Timing divergence, then held through en=0.
    clr = 1'b1; cycle(); clr = 1'b0;
    clean(); en = 1'b1; cycle();
    repeat (8) begin clean(); cycle(); end
    chk("td_state_mon", {62'd0, st0}, 64'd2);
    repeat (5) begin clean(); cycle(); end
    chk("td_cnt5", {32'd0, cnt0}, 64'd5);
    va = 4'b0010; vb = 4'b0000; cycle();
    chk("td_div", {63'd0, dv0}, 64'd1);
    chk("td_dch", {60'd0, dch0}, 64'h2);
    chk("td_dcyc", {32'd0, dcyc0}, 64'd5);
    chk("td_state", {62'd0, st0}, 64'd3);
    en = 1'b0;
    repeat (100) begin clean(); vb = 4'($urandom); cycle(); end
    chk("td_hold_state", {62'd0, st0}, 64'd3);
    chk("td_hold_dcyc", {32'd0, dcyc0}, 64'd5);

    // Data mode with ch0 masked; latched mode/mask ignore later changes.
    clr = 1'b1; cycle(); clr = 1'b0;
    mode = 1'b1; mask = 4'b0001; en = 1'b1;
    va = 4'b0011; vb = 4'b0011; da = {$urandom, $urandom}; db = da;
    cycle();
    mode = 1'b0; mask = 4'b0000;
    repeat (8) cycle();
    db[15:0] = ~da[15:0];
    repeat (4) cycle();
    chk("dm_masked_nodiv", {63'd0, dv0}, 64'd0);
    da[31:16] = 16'hDEAD; db[31:16] = 16'hBEEF;
    cycle();
    chk("dm_dch", {60'd0, dch0}, 64'h2);
    chk("dm_state", {62'd0, st0}, 64'd3);
    clr = 1'b1; cycle(); clr = 1'b0;
    mode = 1'b0; mask = 4'b0001;
    repeat (13) cycle();
    chk("dm_mode0_state", {62'd0, st0}, 64'd2);
    chk("dm_mode0_nodiv", {63'd0, dv0}, 64'd0);

    // Simultaneous events.
    va = 4'b0010; vb = 4'b0000; clr = 1'b1; cycle(); clr = 1'b0;
    chk("sim_clr_state", {62'd0, st0}, 64'd0);
    chk("sim_clr_div", {63'd0, dv0}, 64'd0);
    clean(); mask = '0; en = 1'b1; cycle();
    repeat (8) begin clean(); cycle(); end
    va = 4'b0100; vb = 4'b0000; en = 1'b0; cycle();
    chk("sim_en0_state", {62'd0, st0}, 64'd3);
    chk("sim_en0_dch", {60'd0, dch0}, 64'h4);

    // Saturation of the narrow counter, then a mid-run reset.
    clr = 1'b1; cycle(); clr = 1'b0;
    clean(); en = 1'b1; cycle();
    repeat (20) begin clean(); cycle(); end
    chk("sat_cnt1", {60'd0, cnt1}, 64'd15);
    chk("sat_cnt0", {32'd0, cnt0}, 64'd12);
    rst_n = 1'b0;
    #1;
    chk("rst_state0", {62'd0, st0}, 64'd0);
    chk("rst_cnt0", {32'd0, cnt0}, 64'd0);
    chk("rst_state1", {62'd0, st1}, 64'd0);
    chk("rst_cnt1", {60'd0, cnt1}, 64'd0);
    cycle();
    rst_n = 1'b1; en = 1'b0; cycle();
    chk("rst_rearm_idle", {62'd0, st0}, 64'd0);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      clr   = (m_phase[0] == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 19) != 0);
      mode  = 1'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      clean();
      if ($urandom_range(0, 99) < 3) vb[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 99) < 5) db[$urandom_range(0, 63)] ^= 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/miter_lockstep_monitor.md
# miter_lockstep_monitor

Parametrised divergence monitor for UPEC-DIT miter setups. It sits beside two identical core instances (P1/P2) that are driven with the same public inputs. It compares NUM_CH observation channels of the two copies every cycle, with optional per-channel masking, so secret-dependent data paths can be excluded. It latches the first divergence: which channels and at what monitored cycle. This gives a single sticky `diverged_o` target for formal assertions and simulation benches, replacing ad-hoc per-signal comparisons in miter tops.

## Interface
- NUM_CH, default 4: number of observation channels (1..32).
- CH_W, default 64: data width per channel.
- CNT_W, default 32: width of the monitored-cycle counter.
- SETTLE_CYCLES, default 8: cycles ignored after arming, while both copies leave reset (0 allowed).
- clk_i  in  1  clock; everything is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- en_i  in  1  arm/keep monitoring.
- clr_i  in  1  synchronous clear to IDLE; has priority over en_i.
- mode_i  in  1  0 = timing-only (compare valids), 1 = full (valids and data).
- mask_i  in  NUM_CH  1 = channel ignored.
- valid_a_i, valid_b_i  in  NUM_CH  per-channel event strobes from copy A and copy B.
- data_a_i, data_b_i  in  NUM_CH*CH_W  channel c occupies bits [c*CH_W +: CH_W].
- active_o  out  1  state is MONITOR.
- diverged_o  out  1  sticky divergence flag.
- div_ch_o  out  NUM_CH  channels mismatching in the first divergent cycle.
- div_cycle_o  out  CNT_W  monitored-cycle index of the first divergence.
- cycle_cnt_o  out  CNT_W  monitored cycles so far (saturating).
- state_o  out  2  IDLE=0, SETTLE=1, MONITOR=2, DIVERGED=3.

## Operation
- FSM:
  - IDLE -> SETTLE when en_i=1. If SETTLE_CYCLES=0, IDLE -> MONITOR directly.
  - SETTLE -> MONITOR after SETTLE_CYCLES cycles in SETTLE.
  - MONITOR -> DIVERGED on a sampled mismatch.
  - SETTLE or MONITOR -> IDLE when en_i=0.
  - DIVERGED holds until clr_i; en_i is ignored in DIVERGED.
  - clr_i=1 in any state -> IDLE and clears all outputs and counters.
- Arm: on leaving IDLE, mode_i and mask_i are latched into internal registers. Later changes have no effect until the next arm.
- Per-channel mismatch m[c] = !mask[c] && (valid_a[c]!=valid_b[c] || (mode && valid_a[c] && valid_b[c] && data_a[c]!=data_b[c])).
- Data is never compared when either valid is low, or in mode 0.
- Mismatches are evaluated only in MONITOR. In IDLE, SETTLE and DIVERGED they are ignored.
- On the MONITOR -> DIVERGED edge:
  - div_ch_o <= m (several bits may be set).
  - div_cycle_o <= cycle_cnt_o as it was in that sampled cycle.
  - diverged_o <= 1.
- cycle_cnt_o:
  - increments on every edge where state is MONITOR and there is no mismatch.
  - holds in DIVERGED.
  - saturates at 2^CNT_W-1 (no wrap).
  - is cleared on entering SETTLE, or MONITOR from IDLE.
- Settle counter: internal, width clog2(SETTLE_CYCLES+1), reloaded on each arm.
- All channels masked: mismatch is impossible and the block stays in MONITOR.

## Timing
- Reset (rst_ni=0, asynchronous): state IDLE; active_o=0, diverged_o=0, div_ch_o=0, div_cycle_o=0, cycle_cnt_o=0, state_o=0. Latched mode and mask are cleared to 0.
- All outputs are registered, with no combinational input-to-output path.
- Arm latency: en_i sampled high at edge k -> state SETTLE after k. MONITOR after edge k+SETTLE_CYCLES. active_o is high from then on.
- Detection latency: a mismatch present in the cycle before edge j (state MONITOR) -> diverged_o=1 after edge j (one cycle).
- Simultaneous clr_i and mismatch: clr_i wins; no divergence is recorded.
- Simultaneous en_i=0 and mismatch in MONITOR: the mismatch wins (DIVERGED).
- Reset asserted mid-MONITOR or in DIVERGED: immediate return to reset values. After release, re-arming requires en_i.

## Test plan
- Reset/idle: hold rst_ni=0 with random inputs, then release with en_i=0 for 10 cycles -> all outputs 0, state_o=0.
- Settle masking: SETTLE_CYCLES=8, en_i=1 at edge 0, valid_a_i[0]=1 and valid_b_i[0]=0 only during cycles 1..8 -> no divergence; active_o rises after edge 8; cycle_cnt_o=20 after edge 28.
- Timing divergence: mode 0, MONITOR, 5 clean cycles, then valid_a_i=4'b0010 and valid_b_i=4'b0000 -> next edge diverged_o=1, div_ch_o=4'b0010, div_cycle_o=5, state_o=3; the state holds through 100 cycles of en_i=0.
- Data mode and mask: mode 1, mask 4'b0001. Both valids are 4'b0011; ch0 data differs -> no divergence. Then ch1 data is 0xDEAD vs 0xBEEF -> div_ch_o=4'b0010. In mode 0 the same stimulus gives no divergence.
- Simultaneous events: a mismatch coinciding with clr_i=1 -> state IDLE, diverged_o=0. A mismatch coinciding with en_i=0 -> DIVERGED.
- Saturation and mid-run reset: CNT_W=4, 20 clean MONITOR cycles -> cycle_cnt_o=15 (held). Assert rst_ni low for one cycle -> all outputs 0 immediately.
